// File: rtl/icache_assoc.sv
// Set-associative instruction cache with same-cycle lookup, whole-block refill,
// second-word output for dual fetch, whole-cache flush and saturating hit/miss counters.
module icache_assoc #(
    parameter int unsigned WAYS       = 2,
    parameter int unsigned SETS       = 64,
    parameter int unsigned BLOCK_BITS = 256,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [31:0]           data_addr,
    output logic [31:0]           data,
    output logic [31:0]           data2,
    output logic                  data2_valid,
    output logic                  stop,
    output logic                  iBlkRead,
    output logic [31:0]           request_addr,
    input  logic [BLOCK_BITS-1:0] block_read_fIM,
    input  logic                  block_read_fIM_valid,
    output logic [CNT_W-1:0]      hit_count,
    output logic [CNT_W-1:0]      miss_count
);
    localparam int unsigned WORDS = BLOCK_BITS / 32;
    localparam int unsigned OFF   = $clog2(BLOCK_BITS / 8);
    localparam int unsigned IDX   = $clog2(SETS);
    localparam int unsigned TAG   = 32 - OFF - IDX;
    localparam int unsigned WSEL  = OFF - 2;
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t                state_q, state_d;
    logic [WAYS-1:0]       valid_q [SETS];
    logic [WAYS-1:0]       valid_d [SETS];
    logic [TAG-1:0]        tag_mem  [SETS][WAYS];
    logic [BLOCK_BITS-1:0] data_mem [SETS][WAYS];
    logic [31:0]           req_addr_q, req_addr_d;
    logic [WAY_W-1:0]      vict_q, vict_d;
    logic                  discard_q, discard_d;
    logic [CNT_W-1:0]      hit_count_q, hit_count_d;
    logic [CNT_W-1:0]      miss_count_q, miss_count_d;

    logic [IDX-1:0]        idx;
    logic [TAG-1:0]        tag;
    logic [WSEL-1:0]       wsel, wsel_nx;
    logic                  hit;
    logic [BLOCK_BITS-1:0] hit_blk;
    logic [31:0]           hit_words [WORDS];
    logic [WAY_W-1:0]      ptr_cur, victim;
    logic                  fill;
    logic [IDX-1:0]        fill_idx;
    logic [TAG-1:0]        fill_tag;
    logic                  unused_addr_bits;

    assign idx              = data_addr[OFF+IDX-1:OFF];
    assign tag              = data_addr[31:OFF+IDX];
    assign wsel             = data_addr[OFF-1:2];
    assign unused_addr_bits = ^data_addr[1:0];
    assign fill             = (state_q == REFILL) && block_read_fIM_valid;
    assign fill_idx         = req_addr_q[OFF+IDX-1:OFF];
    assign fill_tag         = req_addr_q[31:OFF+IDX];

    // Way match and block select are OR-muxed so WAYS=1 never indexes past the array.
    always_comb begin
        hit     = 1'b0;
        hit_blk = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_mem[idx][w] == tag) begin
                hit     = 1'b1;
                hit_blk = data_mem[idx][w];
            end
        end
        for (int unsigned i = 0; i < WORDS; i++) begin
            hit_words[i] = hit_blk[i*32 +: 32];
        end
    end

    always_comb begin
        wsel_nx     = wsel + 1'b1;
        data        = hit ? hit_words[wsel] : '0;
        data2_valid = hit && (wsel != WSEL'(WORDS - 1));
        data2       = data2_valid ? hit_words[wsel_nx] : '0;
    end

    always_comb begin
        logic found;
        found  = 1'b0;
        victim = ptr_cur;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!found && !valid_q[idx][w]) begin
                victim = WAY_W'(w);
                found  = 1'b1;
            end
        end
    end

    if (WAYS > 1) begin : g_ptr
        logic [WAY_W-1:0] ptr_q [SETS];
        logic [WAY_W-1:0] ptr_d [SETS];

        always_comb begin
            ptr_d = ptr_q;
            if (fill) ptr_d[fill_idx] = ptr_q[fill_idx] + 1'b1;
        end

        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) ptr_q <= '{default: '0};
            else       ptr_q <= ptr_d;
        end

        assign ptr_cur = ptr_q[idx];
    end else begin : g_noptr
        assign ptr_cur = '0;
    end

    // A flush landing in the fill cycle wins: the block is written but left invalid.
    always_comb begin
        valid_d = valid_q;
        if (fill && !discard_q && !flush) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (vict_q == WAY_W'(w)) valid_d[fill_idx][w] = 1'b1;
            end
        end
        if (flush) valid_d = '{default: '0};
    end

    always_ff @(posedge CLK) begin
        if (fill) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (vict_q == WAY_W'(w)) begin
                    tag_mem[fill_idx][w]  <= fill_tag;
                    data_mem[fill_idx][w] <= block_read_fIM;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            valid_q      <= '{default: '0};
            req_addr_q   <= '0;
            vict_q       <= '0;
            discard_q    <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            req_addr_q   <= req_addr_d;
            vict_q       <= vict_d;
            discard_q    <= discard_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        vict_d       = vict_q;
        discard_d    = discard_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    if (!stall && hit_count_q != '1) hit_count_d = hit_count_q + 1'b1;
                end else if (!stall) begin
                    state_d    = REFILL;
                    req_addr_d = {data_addr[31:OFF], {OFF{1'b0}}};
                    vict_d     = victim;
                    if (miss_count_q != '1) miss_count_d = miss_count_q + 1'b1;
                end
            end
            REFILL: begin
                if (flush) discard_d = 1'b1;
                if (block_read_fIM_valid) begin
                    state_d   = IDLE;
                    discard_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are gated by RESET so IF sees the cache idle as soon as reset rises.
    always_comb begin
        stop         = 1'b0;
        iBlkRead     = 1'b0;
        request_addr = '0;
        if (!RESET) begin
            case (state_q)
                IDLE:   stop = !hit && !stall;
                REFILL: begin
                    stop         = 1'b1;
                    iBlkRead     = 1'b1;
                    request_addr = req_addr_q;
                end
                default: ;
            endcase
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: a behavioural block memory answers refills,
// and hand-computed values are compared after each scenario.
module tb_icache_assoc;
    localparam int BB = 256;

    logic          clk, rst, stall, flush;
    logic [31:0]   data_addr;
    logic [BB-1:0] mem_data;
    logic          mem_valid;
    logic [31:0]   data, data2, request_addr;
    logic          data2_valid, stop, iBlkRead;
    logic [31:0]   hit_count, miss_count;
    logic [31:0]   unused_data, unused_data2, unused_req;
    logic          unused_d2v, unused_stop, unused_rd;
    logic [3:0]    sat_hit, unused_sat_miss;
    int            errors = 0;
    int            checks = 0;
    int            lat = 4;
    int            mem_cnt = 0;
    int            n;

    icache_assoc #(.WAYS(2), .SETS(64), .BLOCK_BITS(BB), .CNT_W(32)) u_dut (
        .CLK(clk), .RESET(rst), .stall(stall), .flush(flush), .data_addr(data_addr),
        .data(data), .data2(data2), .data2_valid(data2_valid), .stop(stop),
        .iBlkRead(iBlkRead), .request_addr(request_addr),
        .block_read_fIM(mem_data), .block_read_fIM_valid(mem_valid),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    icache_assoc #(.WAYS(2), .SETS(64), .BLOCK_BITS(BB), .CNT_W(4)) u_sat (
        .CLK(clk), .RESET(rst), .stall(stall), .flush(flush), .data_addr(data_addr),
        .data(unused_data), .data2(unused_data2), .data2_valid(unused_d2v), .stop(unused_stop),
        .iBlkRead(unused_rd), .request_addr(unused_req),
        .block_read_fIM(mem_data), .block_read_fIM_valid(mem_valid),
        .hit_count(sat_hit), .miss_count(unused_sat_miss)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    // Each instruction word holds its own byte address plus 0x1000_0000.
    function automatic logic [BB-1:0] blk(input logic [31:0] base);
        logic [BB-1:0] b;
        for (int i = 0; i < BB / 32; i++) b[i*32 +: 32] = base + 32'(i * 4) + 32'h1000_0000;
        return b;
    endfunction

    // Memory answers `lat` REFILL cycles after the request appears.
    initial begin
        mem_valid = 1'b0;
        mem_data  = '0;
        forever begin
            @(negedge clk);
            if (iBlkRead && !mem_valid) begin
                mem_cnt++;
                if (mem_cnt >= lat) begin
                    mem_valid = 1'b1;
                    mem_data  = blk(request_addr);
                    mem_cnt   = 0;
                end
            end else begin
                mem_valid = 1'b0;
                if (!iBlkRead) mem_cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_refill(output int cycles);
        cycles = 0;
        while (stop && cycles < 200) begin
            cycles++;
            tick();
        end
    endtask

    task automatic fetch(input logic [31:0] a, output int cycles);
        data_addr = a;
        #1;
        wait_refill(cycles);
    endtask

    task automatic do_reset(input logic [31:0] a);
        rst = 1'b1; stall = 1'b0; flush = 1'b0; data_addr = a;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; data_addr = 32'h0000_0100;
        tick();
        check("rst_stop", {31'd0, stop}, 32'd0);
        check("rst_iblkread", {31'd0, iBlkRead}, 32'd0);
        check("rst_request_addr", request_addr, 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_data2_valid", {31'd0, data2_valid}, 32'd0);
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
        tick();

        // Cold miss on 0x100, latency 4: five stop cycles in total.
        rst = 1'b0;
        #1;
        check("t1_stop_idle", {31'd0, stop}, 32'd1);
        tick();
        check("t1_iblkread", {31'd0, iBlkRead}, 32'd1);
        check("t1_request_addr", request_addr, 32'h0000_0100);
        wait_refill(n);
        check("t1_stop_cycles", 32'(n + 1), 32'd5);
        check("t1_data", data, 32'h1000_0100);
        check("t1_miss_count", miss_count, 32'd1);
        check("t1_hit_before", hit_count, 32'd0);
        tick();
        check("t1_hit_after", hit_count, 32'd1);

        // Second word output.
        data_addr = 32'h0000_0118;
        #1;
        check("t3_data", data, 32'h1000_0118);
        check("t3_data2", data2, 32'h1000_011C);
        check("t3_data2_valid", {31'd0, data2_valid}, 32'd1);
        data_addr = 32'h0000_011C;
        #1;
        check("t3_last_data", data, 32'h1000_011C);
        check("t3_last_data2_valid", {31'd0, data2_valid}, 32'd0);

        // Three blocks into set 0 of a 2-way cache.
        fetch(32'h0000_0000, n);
        check("t2_pen_0", 32'(n), 32'd5);
        fetch(32'h0000_0800, n);
        check("t2_pen_800", 32'(n), 32'd5);
        fetch(32'h0000_1000, n);
        check("t2_pen_1000", 32'(n), 32'd5);
        check("t2_data_1000", data, 32'h1000_1000);
        data_addr = 32'h0000_0800;
        #1;
        check("t2_800_stop", {31'd0, stop}, 32'd0);
        check("t2_800_data", data, 32'h1000_0800);

        // Stalled miss on the evicted 0x0: nothing starts, counters frozen.
        stall = 1'b1;
        data_addr = 32'h0000_0000;
        #1;
        check("t5_stop", {31'd0, stop}, 32'd0);
        check("t2_0_evicted", data, 32'd0);
        repeat (3) tick();
        check("t5_stop_after", {31'd0, stop}, 32'd0);
        check("t5_iblkread", {31'd0, iBlkRead}, 32'd0);
        check("t5_miss_count", miss_count, 32'd4);
        check("t5_hit_count", hit_count, 32'd1);
        stall = 1'b0;
        #1;
        check("t5_release_stop", {31'd0, stop}, 32'd1);
        tick();
        check("t5_release_iblkread", {31'd0, iBlkRead}, 32'd1);
        check("t5_release_req", request_addr, 32'h0000_0000);
        wait_refill(n);
        check("t5_pen", 32'(n), 32'd4);
        check("t5_data", data, 32'h1000_0000);
        check("t5_miss_after", miss_count, 32'd5);

        // Flush mid-refill of 0x200; PC wanders meanwhile.
        do_reset(32'h0000_0200);
        check("t4_stop_idle", {31'd0, stop}, 32'd1);
        tick();
        tick();
        flush = 1'b1;
        data_addr = 32'h0000_0300;
        tick();
        flush = 1'b0;
        check("t4_req_held", request_addr, 32'h0000_0200);
        check("t4_stop_held", {31'd0, stop}, 32'd1);
        data_addr = 32'h0000_0200;
        tick();
        tick();
        check("t4_remiss_stop", {31'd0, stop}, 32'd1);
        check("t4_remiss_idle", {31'd0, iBlkRead}, 32'd0);
        check("t4_miss_one", miss_count, 32'd1);
        tick();
        check("t4_rereq_rd", {31'd0, iBlkRead}, 32'd1);
        check("t4_rereq_addr", request_addr, 32'h0000_0200);
        wait_refill(n);
        check("t4_pen", 32'(n), 32'd4);
        check("t4_data", data, 32'h1000_0200);
        check("t4_miss_two", miss_count, 32'd2);

        // Asynchronous reset in the middle of a long refill.
        lat = 50;
        data_addr = 32'h0000_0100;
        #1;
        check("t6_stop_idle", {31'd0, stop}, 32'd1);
        tick();
        tick();
        #3;
        rst = 1'b1;
        #1;
        check("t6_async_rd", {31'd0, iBlkRead}, 32'd0);
        check("t6_async_stop", {31'd0, stop}, 32'd0);
        @(posedge clk);
        #1;
        lat = 2;
        rst = 1'b0;
        #1;
        check("t6_post_miss", {31'd0, stop}, 32'd1);
        check("t6_post_data", data, 32'd0);
        wait_refill(n);
        check("t6_pen_lat2", 32'(n), 32'd3);
        check("t6_data", data, 32'h1000_0100);
        check("t6_miss_count", miss_count, 32'd1);
        repeat (20) tick();
        check("t6_hit_count", hit_count, 32'd20);
        check("t6_hit_saturated", {28'd0, sat_hit}, 32'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
- Parametrised set-associative instruction cache. It is the next generation of the direct-mapped IC and sits between IF and the instruction-memory block port.
- A lookup of the fetch PC completes in the same cycle. A miss refills a whole block over the block_read_fIM / block_read_fIM_valid handshake.
- Adds configurable ways/sets/block size, a second-word output for superscalar fetch, whole-cache invalidate, and hit/miss counters.

Parameters:
- WAYS, 2, associativity; power of 2, 1..8.
- SETS, 64, sets per way; power of 2, at least 2.
- BLOCK_BITS, 256, block size in bits; power of 2, 64..512.
- CNT_W, 32, width of each performance counter.
- Derived: WORDS=BLOCK_BITS/32, OFF=log2(BLOCK_BITS/8), IDX=log2(SETS), TAG=32-OFF-IDX.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- stall  in  1  pipeline freeze; no new miss is started and no counter updates while high.
- flush  in  1  invalidate every line (syscall).
- data_addr  in  32  fetch PC; bits [1:0] are ignored.
- data  out  32  instruction at data_addr; valid when stop=0.
- data2  out  32  instruction at data_addr+4.
- data2_valid  out  1  data2 is meaningful: hit, and data_addr+4 lies in the same block.
- stop  out  1  cache cannot deliver this cycle; IF must hold.
- iBlkRead  out  1  block read request to memory.
- request_addr  out  32  block-aligned refill address; low OFF bits are 0.
- block_read_fIM  in  BLOCK_BITS  refill data; word 0 in bits [31:0].
- block_read_fIM_valid  in  1  refill data valid for one cycle.
- hit_count  out  CNT_W  lookups that hit.
- miss_count  out  CNT_W  refills started.

Behaviour:
- Storage per set×way: valid bit, TAG-bit tag, BLOCK_BITS data. Per set: a round-robin victim pointer of log2(WAYS) bits; no pointer is kept when WAYS=1.
- Reset (asynchronous):
  - all valid bits 0, all pointers 0, state IDLE, counters 0, discard flag 0.
  - outputs: stop=0, iBlkRead=0, request_addr=0, data=0, data2=0, data2_valid=0.
- Lookup (combinational):
  - index = data_addr[OFF+IDX-1:OFF]; tag = data_addr[31:OFF+IDX].
  - hit = some way has valid and a matching tag. At most one way can match, by construction.
  - On hit: data = the word at data_addr[OFF-1:2].
  - On miss: data=0, data2_valid=0.
- FSM states: IDLE, REFILL.
- IDLE:
  - hit: stop=0. hit_count increments, unless stall is high or hit_count is saturated.
  - miss & ~stall:
    - stop=1 combinationally this cycle.
    - latch the block-aligned address and the victim way.
    - miss_count increments (saturating).
    - go to REFILL.
  - miss & stall: stop=0, no action.
- REFILL:
  - iBlkRead=1 and request_addr = the latched address, held steady until valid.
  - stop=1 regardless of data_addr; a PC change mid-refill does not abort the refill.
  - On block_read_fIM_valid:
    - write data and tag to the latched set/way, set valid (unless discard), advance that set's pointer, go to IDLE.
    - stop stays high in the valid cycle and drops the next cycle, when the lookup hits.
  - Miss penalty = memory latency + 1 cycle.
- Victim choice: the lowest-numbered invalid way in the set. If all ways are valid, the way at the set pointer. The pointer advances modulo WAYS only on install into that set.
- Flush:
  - clears all valid bits at the next edge, in any state.
  - In REFILL, it also sets the discard flag. The returning block is then not marked valid, the refill still completes, and the flag clears on leaving REFILL.
  - flush in the same cycle as block_read_fIM_valid: the block is discarded.
- Counters saturate at all-ones; they never wrap.
- block_read_fIM_valid while in IDLE is ignored.

Test Plan:
- Reset, data_addr=0x0000_0100, memory latency 4: stop=1 for 5 cycles; iBlkRead=1 with request_addr=0x100 in REFILL; then data = word 0 of the block; miss_count=1, hit_count increments from the next cycle.
- Same set, WAYS=2, SETS=64, 256-bit blocks: fetch 0x0000_0000, 0x0000_0800, then 0x0000_1000. The third refill evicts way 0, so 0x0000_0000 misses again and 0x0000_0800 still hits.
- data_addr=0x0000_0118 hit: data2 = word 7, data2_valid=1. data_addr=0x0000_011C: data2_valid=0.
- flush asserted mid-REFILL for 0x200: the refill completes; the next lookup of 0x200 misses and re-requests it; miss_count=2.
- stall=1 with a missing address for 3 cycles: stop=0, iBlkRead=0, counters unchanged. Releasing stall starts the refill.
- RESET asserted mid-REFILL, asynchronously: iBlkRead and stop drop immediately; 0x100 misses after reset. CNT_W=4 with 20 hits: hit_count=15.
